fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Write-side controller for the async FIFO, in the wclk domain.
//  Shares the FIFO write port among NREQ requesters using round-robin arbitration with a burst limit.
//  Owns the binary/Gray write pointer and the registered full flag.
//  Computes full against the read pointer after its 2-flop synchronization into wclk.
// PARAMETERS
//  ADDRSIZE  4  FIFO address bits; depth = 2**ADDRSIZE
//  DATASIZE  8  data word width
//  NREQ      4  number of requesters (>=2)
//  MAXBURST  4  max words per grant before re-arbitration (>=1)
// PORTS
//  wclk     in   1                write-domain clock, rising edge
//  wrst     in   1                async active-low reset
//  req      in   NREQ             req[i]=1: requester i has a word on its data slice
//  wdata_in in   NREQ*DATASIZE    requester i data in bits [i*DATASIZE +: DATASIZE]
//  wd_rptr  in   ADDRSIZE+1       Gray read pointer, already synchronized to wclk
//  gnt      out  NREQ             one-hot; gnt[i]=1 means word i is accepted this cycle
//  winc     out  1                memory write enable (= |gnt)
//  waddr    out  ADDRSIZE         memory write address (binary pointer LSBs)
//  wdata    out  DATASIZE         memory write data (owner's slice)
//  wptr     out  ADDRSIZE+1       registered Gray write pointer, goes to the rclk synchronizer
//  wfull    out  1                registered full flag
// BEHAVIOUR
//  Reset: state=IDLE, owner=0, last=NREQ-1, cnt=0, wbin=0, wptr=0, wfull=0.
//   Reset values of gnt, winc, waddr, wdata are all 0.
//  FSM IDLE:
//   - If |req and !wfull: owner = first i with req[i], searching from last+1 with wrap.
//   - Then cnt=0 and go to BURST. This arbitration cycle writes nothing.
//  FSM BURST:
//   - gnt[owner] = req[owner] & !wfull. gnt is combinational from registered state, req and wfull.
//   - winc = |gnt. Each winc increments cnt.
//   - Go to IDLE and set last=owner when req[owner]=0, or when winc with cnt==MAXBURST-1.
//   - wfull=1 with req[owner]=1: stay in BURST and stall (no gnt), keeping ownership.
//  Handshake:
//   - A requester holds req and data stable until it sees gnt[i].
//   - It may change data on the next cycle. Deasserting req without a gnt drops nothing.
//  Data path:
//   - wdata = wdata_in slice of owner while in BURST, else 0.
//   - waddr = wbin[ADDRSIZE-1:0].
//  Pointer:
//   - wbin_n = wbin + winc, modulo 2**(ADDRSIZE+1).
//   - wgray_n = (wbin_n>>1) ^ wbin_n.
//   - Both registered each cycle; wptr = registered wgray.
//  Full:
//   - wfull <= (wgray_n == {~wd_rptr[ADDRSIZE:ADDRSIZE-1], wd_rptr[ADDRSIZE-2:0]}).
//   - Registered, so it asserts in the cycle after the write that fills the FIFO.
//   - It deasserts in the cycle after the synchronized rptr moves.
//  Full is guaranteed pessimistic: no write is issued while wfull=1.
//  Wrap-around: waddr wraps 2**ADDRSIZE-1 -> 0; the MSB of wbin toggles each lap.
//  Simultaneous events: a req change in the same cycle as a grant decision uses that cycle's value.
//  A new request during BURST waits until the next IDLE arbitration.
//  Reset mid-burst: asynchronous return to the reset state; no partial write is issued after wrst falls.
// TESTING (ADDRSIZE=4, NREQ=4, MAXBURST=4 unless noted)
//  1 Reset: wrst=0 with req=1111 -> gnt=0, winc=0, wptr=0, wfull=0.
//    Release with req=0 -> stays IDLE, wptr stays 00000.
//  2 Single requester: req=0100 held for 6 words, wd_rptr=0.
//    -> 1 IDLE cycle, 4 winc with gnt=0100 and waddr 0..3, 1 IDLE cycle, then 2 more words.
//    -> Final wptr = gray(6) = 00101.
//  3 Round robin, MAXBURST=1, req=1111 held:
//    -> grant order 0,1,2,3,0,1, with an IDLE cycle between each grant.
//  4 Full: wd_rptr=0, write 16 words.
//    -> wfull=1 the cycle after the 16th, gnt=0, wptr = gray(16) = 11000.
//    -> Set wd_rptr=00001: wfull=0 next cycle, one more write to waddr=0.
//  5 Wrap: wd_rptr tracks wptr delayed 3 cycles, 40 writes.
//    -> waddr sequence wraps 15->0 twice, wfull never asserts, no words lost.
//  6 Reset mid-burst: wrst=0 during the 2nd word of a burst.
//    -> All outputs 0 immediately, no winc until re-arbitration after release.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Write-side controller of an asynchronous FIFO, in the wclk domain.
//   Several requesters share the single FIFO write port. Arbitration is
//   round-robin with a per-grant burst limit. The block owns the
//   binary/Gray write pointer and a registered full flag. The full flag is
//   computed against the read pointer after it has been synchronized into
//   wclk.
//
// Ports
//   wclk      in  write-domain clock, rising edge
//   wrst      in  asynchronous active-low reset
//   req       in  [NREQ]          requester i presents a word
//   wdata_in  in  [NREQ*DATASIZE] requester i word at [i*DATASIZE +: DATASIZE]
//   wd_rptr   in  [ADDRSIZE+1]    Gray read pointer, already in wclk domain
//   gnt       out [NREQ]          one-hot; word of requester i accepted now
//   winc      out                 memory write enable
//   waddr     out [ADDRSIZE]      memory write address
//   wdata     out [DATASIZE]      memory write data (owner's slice)
//   wptr      out [ADDRSIZE+1]    registered Gray write pointer
//   wfull     out                 registered full flag
module fifo_wr_arbiter #(
  parameter int ADDRSIZE = 4,
  parameter int DATASIZE = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic                     wclk,
  input  logic                     wrst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATASIZE-1:0] wdata_in,
  input  logic [ADDRSIZE:0]        wd_rptr,
  output logic [NREQ-1:0]          gnt,
  output logic                     winc,
  output logic [ADDRSIZE-1:0]      waddr,
  output logic [DATASIZE-1:0]      wdata,
  output logic [ADDRSIZE:0]        wptr,
  output logic                     wfull
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Counter must hold 0..MAXBURST-1 and still be at least one bit wide.
  localparam int CW = $clog2(MAXBURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [OW-1:0]       last_q, last_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ADDRSIZE:0]   wbin_q, wbin_d;
  logic [ADDRSIZE:0]   wgray_q, wgray_d;
  logic                wfull_q, wfull_d;

  // First requester at or after last+1, wrapping around.
  function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [OW-1:0]   last);
    logic [OW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && r[idx]) begin
        pick  = OW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Grant and datapath are combinational from registered state, so an
  // asynchronous reset silences the write port immediately.
  always_comb begin
    gnt   = '0;
    wdata = '0;
    if (state_q == BURST) begin
      wdata = wdata_in[int'(owner_q)*DATASIZE +: DATASIZE];
      if (req[owner_q] && !wfull_q) begin
        gnt[owner_q] = 1'b1;
      end
    end
  end

  assign winc  = |gnt;
  assign waddr = wbin_q[ADDRSIZE-1:0];
  assign wptr  = wgray_q;
  assign wfull = wfull_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // Arbitration cycle: no write is issued here.
        if ((|req) && !wfull_q) begin
          owner_d = rr_pick(req, last_q);
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        cnt_d = cnt_q + CW'(winc);
        // A full stall with req held keeps ownership; only a dropped
        // request or an exhausted burst hands the port back.
        if (!req[owner_q] || (winc && (cnt_q == CW'(MAXBURST - 1)))) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer advances with each write; full compares the next Gray pointer
  // with the read pointer whose two MSBs are inverted (one lap ahead).
  always_comb begin
    wbin_d  = wbin_q + {{ADDRSIZE{1'b0}}, winc};
    wgray_d = (wbin_d >> 1) ^ wbin_d;
    wfull_d = (wgray_d == {~wd_rptr[ADDRSIZE:ADDRSIZE-1], wd_rptr[ADDRSIZE-2:0]});
  end

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OW'(NREQ - 1);
      cnt_q   <= '0;
      wbin_q  <= '0;
      wgray_q <= '0;
      wfull_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      wfull_q <= wfull_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int A  = 4;
  localparam int D  = 8;
  localparam int N  = 4;
  localparam int MB = 4;

  logic             wclk = 1'b0;
  logic             wrst;
  logic [N-1:0]     req;
  logic [N*D-1:0]   wdata_in;
  logic [A:0]       wd_rptr;
  logic [N-1:0]     gnt;
  logic             winc;
  logic [A-1:0]     waddr;
  logic [D-1:0]     wdata;
  logic [A:0]       wptr;
  logic             wfull;

  fifo_wr_arbiter #(.ADDRSIZE(A), .DATASIZE(D), .NREQ(N), .MAXBURST(MB)) dut (
    .wclk(wclk), .wrst(wrst), .req(req), .wdata_in(wdata_in), .wd_rptr(wd_rptr),
    .gnt(gnt), .winc(winc), .waddr(waddr), .wdata(wdata), .wptr(wptr), .wfull(wfull)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic [N-1:0] gnt;
    logic         winc;
    logic [A-1:0] waddr;
    logic [D-1:0] wdata;
    logic [A:0]   wptr;
    logic         wfull;
  } status_t;

  typedef struct {
    int           idx;
    logic [A-1:0] addr;
    logic [D-1:0] data;
  } wr_t;

  status_t st_q[$];
  wr_t     wr_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  // Requester behaviour
  logic [N-1:0] active;
  logic [D-1:0] dat [N];
  logic [N-1:0] mask;
  int           p_raise, p_keep;
  logic [N-1:0] gnt_prev;

  // Read pointer source: 0 = fixed value, 1 = model write count delayed
  int           rmode, rlag;
  logic [A:0]   rptr_fix;
  int           hist[$];

  // Reference model: FIFO as counts (writes issued, reads seen), arbiter as
  // "who owns the port and how many words it has written".
  int m_busy, m_owner, m_last, m_cnt, m_wr, m_full;

  function automatic logic [A:0] gray(input int b);
    logic [A:0] v;
    v = b[A:0];
    return v ^ (v >> 1);
  endfunction

  function automatic int gray2bin(input logic [A:0] g);
    int b;
    b = 0;
    for (int i = A; i >= 0; i--) b = (b << 1) | ((b & 1) ^ int'(g[i]));
    return b;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = N - 1; m_cnt = 0; m_wr = 0; m_full = 0;
    hist.delete();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
    end
  endtask

  // One clock cycle: update requesters, drive inputs, predict outputs.
  task automatic do_cycle(input logic rst_v);
    status_t e;
    logic    g;
    int      rb;
    @(posedge wclk);
    #1;
    cycle++;
    for (int i = 0; i < N; i++) begin
      if (gnt_prev[i]) begin
        if (mask[i] && ($urandom % 100) < p_keep) dat[i] = D'($urandom);
        else active[i] = 1'b0;
      end else if (!active[i]) begin
        if (mask[i] && ($urandom % 100) < p_raise) begin
          active[i] = 1'b1;
          dat[i] = D'($urandom);
        end
      end else if (!mask[i]) begin
        active[i] = 1'b0;
      end
    end
    if (rmode == 1) wd_rptr = (hist.size() > rlag) ? gray(hist[hist.size()-1-rlag]) : '0;
    else            wd_rptr = rptr_fix;
    req = active;
    for (int i = 0; i < N; i++) wdata_in[i*D +: D] = dat[i];
    wrst = rst_v;

    e.gnt = '0; e.winc = 1'b0; e.waddr = '0; e.wdata = '0; e.wptr = '0; e.wfull = 1'b0;
    if (!rst_v) begin
      model_reset();
    end else begin
      e.wptr  = gray(m_wr);
      e.waddr = A'(m_wr % (1 << A));
      e.wfull = m_full[0];
      g = 1'b0;
      if (m_busy == 0) begin
        if (req != 0 && m_full == 0) begin
          for (int k = N; k >= 1; k--)
            if (req[(m_last + k) % N]) m_owner = (m_last + k) % N;
          m_cnt = 0;
          m_busy = 1;
        end
      end else begin
        e.wdata = dat[m_owner];
        if (req[m_owner] && m_full == 0) begin
          g = 1'b1;
          e.gnt[m_owner] = 1'b1;
          wr_q.push_back('{idx: m_owner, addr: e.waddr, data: dat[m_owner]});
          m_wr = (m_wr + 1) % (2 << A);
          m_cnt++;
        end
        if (!req[m_owner] || (g && m_cnt == MB)) begin
          m_busy = 0;
          m_last = m_owner;
        end
      end
      e.winc = g;
      rb = gray2bin(wd_rptr);
      m_full = (((m_wr - rb + (2 << A)) % (2 << A)) == (1 << A)) ? 1 : 0;
      hist.push_back(m_wr);
    end
    gnt_prev = e.gnt;
    st_q.push_back(e);
  endtask

  // Monitor: compares every presented cycle, and every write against the
  // expected-write queue.
  always @(negedge wclk) begin
    status_t e;
    wr_t     w;
    int      gi;
    if (st_q.size() > 0) begin
      e = st_q.pop_front();
      chk("gnt", 32'(gnt), 32'(e.gnt));
      chk("winc", 32'(winc), 32'(e.winc));
      chk("waddr", 32'(waddr), 32'(e.waddr));
      chk("wdata", 32'(wdata), 32'(e.wdata));
      chk("wptr", 32'(wptr), 32'(e.wptr));
      chk("wfull", 32'(wfull), 32'(e.wfull));
      if (winc === 1'b1) begin
        gi = -1;
        for (int i = 0; i < N; i++) if (gnt[i] === 1'b1) gi = i;
        if (wr_q.size() == 0) begin
          chk("write_unexpected", 32'(gi), 32'hFFFF_FFFF);
        end else begin
          w = wr_q.pop_front();
          chk("write_idx", 32'(gi), 32'(w.idx));
          chk("write_addr", 32'(waddr), 32'(w.addr));
          chk("write_data", 32'(wdata), 32'(w.data));
        end
      end
    end
  end

  task automatic run(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b1);
  endtask

  initial begin
    int waited;
    wrst = 1'b0; req = '0; wdata_in = '0; wd_rptr = '0;
    active = '0; mask = '0; gnt_prev = '0;
    for (int i = 0; i < N; i++) dat[i] = '0;
    p_raise = 0; p_keep = 0; rmode = 0; rlag = 0; rptr_fix = '0;
    model_reset();

    // Reset held with every requester asking, then released with none.
    mask = '1; p_raise = 100;
    repeat (3) do_cycle(1'b0);
    mask = '0;
    run(4);

    // Single requester, six words.
    mask = 4'b0100; p_raise = 100; p_keep = 100;
    run(8);
    mask = '0;
    run(3);

    // Fill to full against a parked read pointer, then let one read through.
    repeat (2) do_cycle(1'b0);
    mask = '1; p_raise = 60; p_keep = 80; rptr_fix = '0;
    run(40);
    rptr_fix = 5'b00001;
    run(10);
    mask = '0;
    run(3);
    repeat (2) do_cycle(1'b0);

    // Read pointer follows the write pointer: short lag, then long lag.
    rmode = 1; rlag = 3; mask = '1; p_raise = 50; p_keep = 70;
    run(300);
    rlag = 18;
    run(200);

    // Reset during the second word of a burst.
    p_raise = 100; p_keep = 100;
    waited = 0;
    while (!(m_busy == 1 && m_cnt == 1) && waited < 50) begin
      do_cycle(1'b1);
      waited++;
    end
    if (waited >= 50) chk("midburst_timeout", 32'(waited), 32'd0);
    repeat (2) do_cycle(1'b0);
    p_raise = 50; p_keep = 70;
    run(30);
    mask = '0;
    run(6);

    @(posedge wclk);
    @(negedge wclk);
    #1;
    chk("pending_writes", 32'(wr_q.size()), 32'd0);
    chk("pending_status", 32'(st_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
